// File: rtl/opb_sync_pulse_gen_if.sv
// OPB slave-side bus bundle for the sync pulse generator register window.
// Handshake: OPB_select marks a valid request; the slave answers with a single
// Sl_xferAck cycle, and the master holds address/data/RNW/BE until it sees it.
interface opb_sync_pulse_gen_if;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_sync_pulse_gen.sv
// Periodic sync pulse generator with an OPB register window: programmable
// period/width, per-output mask, one-shot mode and a running pulse counter.
module opb_sync_pulse_gen #(
    parameter logic [31:0] C_BASEADDR   = 32'h0100E200,
    parameter logic [31:0] C_HIGHADDR   = 32'h0100E2FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          NUM_OUT      = 4,
    parameter int          CNT_WIDTH    = 32
) (
    input  logic                   OPB_Clk,
    input  logic                   OPB_Rst_n,
    opb_sync_pulse_gen_if.slave    bus,
    output logic [NUM_OUT-1:0]     sync_out,
    output logic [31:0]            pulse_count,
    output logic [1:0]             dbg_state_o
);

    localparam logic [C_OPB_AWIDTH-1:0] BASE_A = C_OPB_AWIDTH'(C_BASEADDR);
    localparam logic [C_OPB_AWIDTH-1:0] HIGH_A = C_OPB_AWIDTH'(C_HIGHADDR);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]    period_sh_q, period_sh_d, width_sh_q, width_sh_d;
    logic [CNT_WIDTH-1:0]    period_q, width_q;
    logic                    enable_q, enable_d, one_shot_q, one_shot_d, arm_q, arm_d;
    logic [31:0]             mask_q, mask_d;
    logic [31:0]             pcount_q, pcount_d;
    logic [NUM_OUT-1:0]      sync_q, sync_d;
    logic                    ack_q, ack_d;
    logic [C_OPB_DWIDTH-1:0] dbus_q, dbus_d, rdata;

    logic [C_OPB_AWIDTH-1:0] addr;
    logic [31:0]             wdata, ctrl_merged;
    logic [3:0]              be;
    logic [2:0]              reg_idx;
    logic                    hit, wr_en, cnt_clr, load_act, pulse;
    logic [CNT_WIDTH-1:0]    p_eff, p_last, w_floor, w_eff;

    // Big-endian bus: BE[0]/DBus[0] are the most significant lane/bit.
    assign addr    = bus.OPB_ABus;
    assign wdata   = bus.OPB_DBus;
    assign be      = bus.OPB_BE;
    assign reg_idx = bus.OPB_ABus[27:29];
    assign hit     = bus.OPB_select && (addr >= BASE_A) && (addr <= HIGH_A);
    assign wr_en   = ack_q && hit && !bus.OPB_RNW;

    function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  lane_en);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    assign ctrl_merged = merge_be({30'b0, one_shot_q, enable_q}, wdata, be);

    always_comb begin
        enable_d    = enable_q;
        one_shot_d  = one_shot_q;
        arm_d       = 1'b0;
        period_sh_d = period_sh_q;
        width_sh_d  = width_sh_q;
        mask_d      = mask_q;
        cnt_clr     = 1'b0;
        if (wr_en) begin
            case (reg_idx)
                3'd0: begin
                    enable_d   = ctrl_merged[0];
                    one_shot_d = ctrl_merged[1];
                    arm_d      = ctrl_merged[2];
                end
                3'd1: period_sh_d = CNT_WIDTH'(merge_be(32'(period_sh_q), wdata, be));
                3'd2: width_sh_d  = CNT_WIDTH'(merge_be(32'(width_sh_q), wdata, be));
                3'd3: mask_d      = merge_be(mask_q, wdata, be);
                3'd4: cnt_clr     = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_idx)
            3'd0: rdata = C_OPB_DWIDTH'({30'b0, one_shot_q, enable_q});
            3'd1: rdata = C_OPB_DWIDTH'(32'(period_sh_q));
            3'd2: rdata = C_OPB_DWIDTH'(32'(width_sh_q));
            3'd3: rdata = C_OPB_DWIDTH'(mask_q);
            3'd4: rdata = C_OPB_DWIDTH'(pcount_q);
            3'd5: rdata = C_OPB_DWIDTH'({31'b0, state_q == ST_RUN});
            default: rdata = '0;
        endcase
        ack_d  = hit && !ack_q;
        dbus_d = (hit && !ack_q && bus.OPB_RNW) ? rdata : '0;
    end

    // Degenerate settings are clamped so there is always a low phase.
    assign p_eff   = (period_q < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : period_q;
    assign p_last  = p_eff - CNT_WIDTH'(1);
    assign w_floor = (width_q == '0) ? CNT_WIDTH'(1) : width_q;
    assign w_eff   = (w_floor > p_last) ? p_last : w_floor;
    assign pulse   = (state_q == ST_RUN) && (cnt_q < w_eff);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_act = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (enable_q && (!one_shot_q || arm_q)) begin
                    state_d  = ST_RUN;
                    load_act = 1'b1;
                end
            end
            ST_RUN: begin
                if (cnt_q == p_last) begin
                    cnt_d    = '0;
                    load_act = 1'b1;
                    if (one_shot_q) state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (!enable_q) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            load_act = 1'b0;
        end
    end

    always_comb begin
        pcount_d = pcount_q;
        if (cnt_clr) begin
            pcount_d = '0;
        end else if (state_q == ST_RUN && cnt_q == '0) begin
            pcount_d = pcount_q + 32'd1;
        end
        sync_d = pulse ? mask_q[NUM_OUT-1:0] : '0;
    end

    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            period_sh_q <= '0;
            width_sh_q  <= '0;
            period_q    <= '0;
            width_q     <= '0;
            enable_q    <= 1'b0;
            one_shot_q  <= 1'b0;
            arm_q       <= 1'b0;
            mask_q      <= '1;
            pcount_q    <= '0;
            sync_q      <= '0;
            ack_q       <= 1'b0;
            dbus_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            period_sh_q <= period_sh_d;
            width_sh_q  <= width_sh_d;
            if (load_act) begin
                period_q <= period_sh_q;
                width_q  <= width_sh_q;
            end
            enable_q    <= enable_d;
            one_shot_q  <= one_shot_d;
            arm_q       <= arm_d;
            mask_q      <= mask_d;
            pcount_q    <= pcount_d;
            sync_q      <= sync_d;
            ack_q       <= ack_d;
            dbus_q      <= dbus_d;
        end
    end

    assign bus.Sl_DBus    = dbus_q;
    assign bus.Sl_xferAck = ack_q;
    assign bus.Sl_errAck  = 1'b0;
    assign bus.Sl_retry   = 1'b0;
    assign bus.Sl_toutSup = 1'b0;
    assign sync_out       = sync_q;
    assign pulse_count    = pcount_q;
    assign dbg_state_o    = state_q;

    logic unused_sig;
    assign unused_sig = &{1'b0, bus.OPB_seqAddr, ctrl_merged[31:3]};

endmodule

// File: tb/tb_opb_sync_pulse_gen.sv
// Self-checking bench for opb_sync_pulse_gen: register vectors through a
// read scoreboard, waveform checks against a period/width model, reset cases.
module tb_opb_sync_pulse_gen;

    localparam logic [31:0] BASE = 32'h0100E200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  sync_out;
    logic [31:0] pulse_count;
    logic [1:0]  dbg_state;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        int          idx;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[13];
    logic [31:0] rst_vals[6];

    opb_sync_pulse_gen_if bus_if();

    opb_sync_pulse_gen #(.NUM_OUT(4), .CNT_WIDTH(32)) dut (
        .OPB_Clk     (clk),
        .OPB_Rst_n   (rst_n),
        .bus         (bus_if),
        .sync_out    (sync_out),
        .pulse_count (pulse_count),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic bus_idle();
        bus_if.OPB_ABus    = '0;
        bus_if.OPB_BE      = '0;
        bus_if.OPB_DBus    = '0;
        bus_if.OPB_RNW     = 1'b0;
        bus_if.OPB_select  = 1'b0;
        bus_if.OPB_seqAddr = 1'b0;
    endtask

    task automatic opb_xfer(input logic [31:0] addr, input logic rnw, input logic [3:0] be,
                            input logic [31:0] data, output logic [31:0] rd, output logic acked);
        bus_if.OPB_ABus   = addr;
        bus_if.OPB_BE     = be;
        bus_if.OPB_DBus   = rnw ? 32'h0 : data;
        bus_if.OPB_RNW    = rnw;
        bus_if.OPB_select = 1'b1;
        acked = 1'b0;
        rd    = '0;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(posedge clk); #1;
            if (bus_if.Sl_xferAck) begin
                acked = 1'b1;
                rd    = bus_if.Sl_DBus;
            end
        end
        if (acked) begin
            @(posedge clk); #1;
        end
        bus_idle();
    endtask

    task automatic wr(input int idx, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] rd;
        logic        a;
        opb_xfer(BASE + 32'(idx) * 4, 1'b0, be, d, rd, a);
        total++;
        if (!a) begin
            bad++;
            $display("FAIL wr_ack idx=%0d: got no ack want ack", idx);
        end
    endtask

    task automatic rd_raw(input int idx, output logic [31:0] d);
        logic a;
        opb_xfer(BASE + 32'(idx) * 4, 1'b1, 4'hF, 32'h0, d, a);
        total++;
        if (!a) begin
            bad++;
            $display("FAIL rd_ack idx=%0d: got no ack want ack", idx);
        end
    endtask

    // scoreboard: expectation queued when the read is issued, popped on ack
    task automatic rd_sb(input string name, input int idx, input logic [31:0] exp);
        logic [31:0] rd, e;
        logic        a;
        exp_q.push_back(exp);
        opb_xfer(BASE + 32'(idx) * 4, 1'b1, 4'hF, 32'h0, rd, a);
        e = exp_q.pop_front();
        if (a) begin
            check(name, rd, e);
        end else begin
            total++;
            bad++;
            $display("FAIL %s: got no ack want data %h", name, e);
        end
    endtask

    task automatic wait_level(input logic want_high, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if ((sync_out != 4'h0) == want_high) ok = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_rise(output logic ok);
        logic ok0, ok1;
        wait_level(1'b0, 64, ok0);
        wait_level(1'b1, 64, ok1);
        ok = ok0 && ok1;
    endtask

    task automatic check_wave(input string name, input int p, input int w, input logic [3:0] m);
        logic       ok;
        logic [3:0] e;
        int         errs;
        errs = 0;
        wait_rise(ok);
        if (ok) begin
            for (int k = 0; k < 3 * p; k++) begin
                e = ((k % p) < w) ? m : 4'h0;
                if (sync_out !== e) errs++;
                @(posedge clk); #1;
            end
        end
        total++;
        if (!ok || errs != 0) begin
            bad++;
            $display("FAIL %s: got edge_found=%0d bad_cycles=%0d want edge_found=1 bad_cycles=0",
                     name, ok, errs);
        end
    endtask

    task automatic monitor(input int n, output int rises, output int highs);
        logic [3:0] prev;
        prev  = sync_out;
        rises = 0;
        highs = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (sync_out != 4'h0) highs++;
            if (sync_out != 4'h0 && prev == 4'h0) rises++;
            prev = sync_out;
        end
    endtask

    initial begin
        logic [31:0] c0, c1, p0;
        logic        ok;
        int          t0, t1, t2, rises, highs, acks;

        rst_vals = '{32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0};
        vecs[0]  = '{1, 4'b1111, 32'h12345678, 32'h12345678};
        vecs[1]  = '{1, 4'b1000, 32'hAB000000, 32'hAB345678};
        vecs[2]  = '{2, 4'b0110, 32'h00CDEF00, 32'h00CDEF00};
        vecs[3]  = '{2, 4'b0001, 32'h11223344, 32'h00CDEF44};
        vecs[4]  = '{3, 4'b0001, 32'hAABBCCDD, 32'hFFFFFFDD};
        vecs[5]  = '{3, 4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[6]  = '{0, 4'b1111, 32'hFFFFFFF8, 32'h00000000};
        vecs[7]  = '{5, 4'b1111, 32'hFFFFFFFF, 32'h00000000};
        vecs[8]  = '{6, 4'b1111, 32'hFFFFFFFF, 32'h00000000};
        vecs[9]  = '{7, 4'b1111, 32'hFFFFFFFF, 32'h00000000};
        vecs[10] = '{4, 4'b1111, 32'h12345678, 32'h00000000};
        vecs[11] = '{1, 4'b1111, 32'h00000000, 32'h00000000};
        vecs[12] = '{2, 4'b1111, 32'h00000000, 32'h00000000};

        bus_idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sync_out", 32'(sync_out), 32'h0);
        check("rst_ack", 32'(bus_if.Sl_xferAck), 32'h0);
        check("rst_dbus", bus_if.Sl_DBus, 32'h0);
        check("rst_pulse_count", pulse_count, 32'h0);
        check("rst_state", 32'(dbg_state), 32'h0);
        check("tied_zero", 32'({bus_if.Sl_errAck, bus_if.Sl_retry, bus_if.Sl_toutSup}), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) rd_sb($sformatf("rst_reg%0d", i), i, rst_vals[i]);

        for (int i = 0; i < 13; i++) begin
            wr(vecs[i].idx, vecs[i].be, vecs[i].wdata);
            rd_sb($sformatf("vec%0d", i), vecs[i].idx, vecs[i].exp);
        end

        opb_xfer(32'h0100E300, 1'b1, 4'hF, 32'h0, c0, ok);
        check("outside_high_ack", 32'(ok), 32'h0);
        opb_xfer(32'h0100E1FC, 1'b0, 4'hF, 32'h5, c0, ok);
        check("outside_low_ack", 32'(ok), 32'h0);
        rd_sb("outside_no_write", 3, 32'hFFFFFFFF);

        // select held for three cycles yields a single ack inside that window
        bus_if.OPB_ABus   = BASE + 32'hC;
        bus_if.OPB_RNW    = 1'b1;
        bus_if.OPB_BE     = 4'hF;
        bus_if.OPB_select = 1'b1;
        acks = 0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (bus_if.Sl_xferAck) acks++;
        end
        @(posedge clk); #1;
        bus_idle();
        repeat (2) @(posedge clk);
        #1;
        check("ack_once_held", 32'(acks), 32'd1);

        wr(1, 4'hF, 32'd10);
        wr(2, 4'hF, 32'd3);
        wr(0, 4'hF, 32'h1);
        check_wave("wave_p10_w3", 10, 3, 4'hF);
        p0 = pulse_count;
        repeat (10) @(posedge clk);
        #1;
        check("pulse_count_step", pulse_count - p0, 32'd1);
        rd_raw(4, c0);
        repeat (48) @(posedge clk);
        #1;
        rd_raw(4, c1);
        check("count_reg_delta", c1 - c0, 32'd5);
        rd_sb("status_running", 5, 32'h1);

        wr(1, 4'hF, 32'd0);
        wr(2, 4'hF, 32'd0);
        repeat (25) @(posedge clk);
        #1;
        check_wave("wave_p0_w0", 2, 1, 4'hF);
        wr(2, 4'hF, 32'd50);
        wr(1, 4'hF, 32'd4);
        repeat (10) @(posedge clk);
        #1;
        check_wave("wave_p4_w50", 4, 3, 4'hF);

        wr(1, 4'hF, 32'd8);
        wr(2, 4'hF, 32'd3);
        repeat (20) @(posedge clk);
        #1;
        wait_rise(ok);
        t0 = cyc;
        repeat (2) @(posedge clk);
        #1;
        wr(1, 4'hF, 32'd20);
        wait_rise(ok);
        t1 = cyc;
        check("period_old_len", 32'(t1 - t0), 32'd8);
        wait_rise(ok);
        t2 = cyc;
        check("period_new_len", 32'(t2 - t1), 32'd20);

        wr(3, 4'b0001, 32'hAABBCCDD);
        check_wave("wave_mask_d", 20, 3, 4'hD);

        wr(0, 4'hF, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        monitor(30, rises, highs);
        check("disabled_quiet", 32'(highs), 32'd0);
        check("disabled_state", 32'(dbg_state), 32'h0);
        rd_sb("status_idle", 5, 32'h0);

        wr(3, 4'hF, 32'hFFFFFFFF);
        wr(1, 4'hF, 32'd5);
        wr(2, 4'hF, 32'd2);
        p0 = pulse_count;
        wr(0, 4'hF, 32'h7);
        monitor(40, rises, highs);
        check("oneshot_rises", 32'(rises), 32'd1);
        check("oneshot_width", 32'(highs), 32'd2);
        check("oneshot_count", pulse_count - p0, 32'd1);
        rd_sb("oneshot_status", 5, 32'h0);
        rd_sb("oneshot_ctrl", 0, 32'h3);
        check("oneshot_state", 32'(dbg_state), 32'h0);

        wr(1, 4'hF, 32'd30);
        fork
            monitor(100, rises, highs);
            begin
                wr(0, 4'hF, 32'h7);
                repeat (6) @(posedge clk);
                #1;
                wr(0, 4'hF, 32'h7);
            end
        join
        check("arm_in_run_rises", 32'(rises), 32'd1);

        // reset while a pulse is on the outputs
        wr(3, 4'hF, 32'h5);
        wr(1, 4'hF, 32'd10);
        wr(2, 4'hF, 32'd3);
        wr(0, 4'hF, 32'h1);
        wait_rise(ok);
        check("pre_reset_pulse", 32'(sync_out), 32'h5);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midpulse_sync_out", 32'(sync_out), 32'h0);
        check("midpulse_count", pulse_count, 32'h0);
        check("midpulse_state", 32'(dbg_state), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) rd_sb($sformatf("post_rst_reg%0d", i), i, rst_vals[i]);
        monitor(12, rises, highs);
        check("post_rst_quiet", 32'(highs), 32'd0);

        // reset in the ack cycle
        bus_if.OPB_ABus   = BASE + 32'hC;
        bus_if.OPB_RNW    = 1'b1;
        bus_if.OPB_BE     = 4'hF;
        bus_if.OPB_select = 1'b1;
        @(posedge clk); #1;
        check("midack_seen", 32'(bus_if.Sl_xferAck), 32'h1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midack_ack", 32'(bus_if.Sl_xferAck), 32'h0);
        check("midack_dbus", bus_if.Sl_DBus, 32'h0);
        bus_idle();
        rst_n = 1'b1;

        // reset in the hit cycle drops the pending ack
        @(posedge clk); #1;
        bus_if.OPB_ABus   = BASE;
        bus_if.OPB_RNW    = 1'b1;
        bus_if.OPB_select = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("pending_ack_dropped", 32'(bus_if.Sl_xferAck), 32'h0);
        bus_idle();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("no_late_ack", 32'(bus_if.Sl_xferAck), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/opb_sync_pulse_gen.md
OPB_SYNC_PULSE_GEN -- requirements
Module: opb_sync_pulse_gen

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h0100E200, first byte of the register window.
REQ-002 SHALL have parameter C_HIGHADDR, default 32'h0100E2FF, last byte of the register window.
REQ-003 SHALL have parameter C_OPB_AWIDTH, default 32, address width; C_OPB_DWIDTH, default 32, data width.
REQ-004 SHALL have parameter NUM_OUT, default 4, sync output count (1..32); CNT_WIDTH, default 32, counter width (2..32).
REQ-005 OPB_Clk  in  1  sole clock; all logic on rising edge.
REQ-006 OPB_Rst_n  in  1  reset, synchronous, active-low.
REQ-007 OPB_ABus  in  [0:31]  address; OPB_BE  in  [0:3]  byte enables; OPB_DBus  in  [0:31]  write data.
REQ-008 OPB_RNW  in  1  1=read; OPB_select  in  1  transfer valid; OPB_seqAddr  in  1  ignored.
REQ-009 Sl_DBus  out  [0:31]  read data; Sl_xferAck  out  1  transfer done.
REQ-010 Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0.
REQ-011 sync_out  out  [NUM_OUT-1:0]  masked sync pulses; pulse_count  out  [31:0]  pulses issued.

Function
REQ-012 Hit = OPB_select and C_BASEADDR <= OPB_ABus <= C_HIGHADDR; register index = OPB_ABus[27:29].
REQ-013 Sl_xferAck SHALL be registered: high exactly one cycle, the cycle after a hit with Sl_xferAck low; no re-ack while select stays high in the ack cycle.
REQ-014 Sl_DBus SHALL carry read data only in ack cycles of reads, else all zero.
REQ-015 Writes SHALL apply per byte lane (OPB_BE[0] = bits 0:7, big-endian) in the ack cycle.
REQ-016 Map: 0 CTRL (bit31 enable, bit30 one_shot, bit29 arm), 1 PERIOD, 2 WIDTH, 3 MASK, 4 COUNT (RO), 5 STATUS (RO, bit31 running); 6-7 read 0, writes ignored.
REQ-017 arm SHALL be self-clearing: reads 0, one-cycle internal pulse.
REQ-018 PERIOD/WIDTH use low CNT_WIDTH bits; writes go to shadow, loaded to active at each period boundary and on IDLE->RUN.
REQ-019 Effective period P = max(PERIOD,2); effective width W = min(max(WIDTH,1), P-1).
REQ-020 FSM states IDLE, RUN, DONE.
REQ-021 IDLE->RUN: enable=1 and one_shot=0, or enable=1 and one_shot=1 and arm pulse; counter cleared to 0.
REQ-022 RUN: counter counts 0..P-1 then wraps to 0; pulse = (counter < W).
REQ-023 RUN wrap with one_shot=1 -> DONE; DONE->IDLE next cycle.
REQ-024 enable=0 in any state SHALL force IDLE next cycle, counter 0, pulse low; no partial pulse completion.
REQ-025 sync_out SHALL be registered: pulse AND MASK[NUM_OUT-1:0]; one-cycle latency from counter.
REQ-026 pulse_count SHALL increment at each counter=0 in RUN, wrap 2^32-1->0, clear on COUNT write (any data); increment wins over simultaneous clear is NOT allowed: clear wins.
REQ-027 Arm while RUN SHALL be ignored.

Reset
REQ-028 On OPB_Rst_n low at a clock edge: FSM IDLE, counter 0, CTRL 0, PERIOD/WIDTH shadow and active 0, MASK all ones, pulse_count 0, sync_out 0, Sl_xferAck 0, Sl_DBus 0.
REQ-029 Reset mid-transfer SHALL drop any pending ack; reset mid-pulse SHALL drive sync_out 0 next cycle.

Verification
REQ-030 Write PERIOD=10, WIDTH=3, CTRL=0x00000001 -> sync_out=0xF for 3 of every 10 cycles; COUNT increments per period.
REQ-031 CTRL one_shot+arm (0x00000007) with PERIOD=5, WIDTH=2 -> exactly one 2-cycle pulse, STATUS running=0 after DONE.
REQ-032 PERIOD=0, WIDTH=0 -> P=2, W=1: alternating 1/0; WIDTH=50, PERIOD=4 -> high 3, low 1.
REQ-033 Write PERIOD=20 during running PERIOD=8 -> current period ends at 8, next is 20.
REQ-034 Write BE=0b0001 data 0xAABBCCDD to MASK (0xFFFFFFFF) -> reads 0xFFFFFFDD; ack one cycle with select held 3 cycles; address outside window -> no ack.
REQ-035 Assert OPB_Rst_n=0 mid-pulse and mid-ack -> next cycle sync_out=0, Sl_xferAck=0, all registers at reset values.
